// File: rtl/kbd_fifo.sv
// PS/2 scancode buffer: folds F0 break prefixes into bit 7 and queues the
// result in a show-ahead FIFO with a head-change IRQ pulse and sticky overflow.
module kbd_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_hit,
  input  logic          rd,
  input  logic          clr,
  output logic [7:0]    data_o,
  output logic          ready,
  output logic          irq,
  output logic          overflow,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          brk_q, brk_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic          ready_q, ready_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    push_byte;
  logic          is_prefix, cand, pop, push, bypass, flush;

  assign flush = !resetn || clr;

  always_comb begin
    is_prefix = ps2_hit && (ps2_data == 8'hF0);
    cand      = ps2_hit && !is_prefix;
    push_byte = brk_q ? (ps2_data | 8'h80) : ps2_data;
    pop       = rd && (count_q != '0);
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    push      = cand && ((count_q != FULL) || pop);

    brk_d = brk_q;
    if (is_prefix) begin
      brk_d = 1'b1;
    end else if (cand) begin
      brk_d = 1'b0;
    end

    ovf_d    = ovf_q || (cand && !push);
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // The new head is the byte being written this cycle: skip the memory.
    bypass  = push && (rd_ptr_d == wr_ptr_q);
    ready_d = (count_d != '0);
    data_d  = 8'h00;
    if (ready_d) begin
      data_d = bypass ? push_byte : mem_q[rd_ptr_d];
    end
    irq_d = (push && (count_q == '0)) || (pop && (count_d != '0));
  end

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      brk_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      ready_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      brk_q    <= brk_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
    end
  end

  assign data_o   = data_q;
  assign ready    = ready_q;
  assign irq      = irq_q;
  assign overflow = ovf_q;
  assign count    = count_q;

endmodule
